uart_byte_receiver: RTL and testbench

//   UART RX front end (8N1, LSB first) feeding the command accumulator.
//   - Synchronises the asynchronous rx pin and recovers bytes by mid-bit sampling.
//   - Presents each byte on output_byte with an accumulate strobe of fixed width.
//   - The downstream stage acts on accumulate rising and re-arms on accumulate falling.

---
 rtl/uart_byte_receiver.sv | 143 ++++++++++++++
 tb/tb_uart_byte_receiver.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver (LSB first) with a two-flop rx synchroniser and mid-bit sampling.
// Each good byte is presented on output_byte with a fixed-width accumulate strobe.
module uart_byte_receiver #(
   parameter int CLKS_PER_BIT  = 434,
   parameter int STROBE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] output_byte,
   output logic       accumulate,
   output logic       framing_error,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int STB_W = $clog2(STROBE_CYCLES + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [STB_W-1:0] STB_LOAD  = STB_W'(STROBE_CYCLES);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state, next_state;
   logic             rx_meta, rx_s;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic [STB_W-1:0] strobe_cnt;

   logic cnt_clr, idx_clr, idx_inc, shift_en, load_byte, stop_err;

   // Synchroniser flops reset to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge value,
         // which is what makes this a two-stage chain rather than a single wire.
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      next_state = state;
      cnt_clr    = 1'b0;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      shift_en   = 1'b0;
      load_byte  = 1'b0;
      stop_err   = 1'b0;
      case (state)
         WAIT_IDLE: begin
            if (!rx_s)
               cnt_clr = 1'b1;
            else if (bit_cnt == BIT_LAST)
               next_state = IDLE;
         end
         IDLE: begin
            if (!rx_s)
               next_state = START;
         end
         START: begin
            if (bit_cnt == HALF_LAST) begin
               // A start bit that is high again at mid-bit was only a glitch.
               next_state = rx_s ? IDLE : DATA;
               idx_clr    = 1'b1;
            end
         end
         DATA: begin
            if (bit_cnt == BIT_LAST) begin
               shift_en = 1'b1;
               cnt_clr  = 1'b1;
               if (bit_idx == 3'd7)
                  next_state = STOP;
               else
                  idx_inc = 1'b1;
            end
         end
         STOP: begin
            if (bit_cnt == BIT_LAST) begin
               if (rx_s) begin
                  load_byte  = 1'b1;
                  next_state = IDLE;
               end else begin
                  stop_err   = 1'b1;
                  next_state = WAIT_IDLE;
               end
            end
         end
         default: next_state = WAIT_IDLE;
      endcase
      if (next_state != state)
         cnt_clr = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= WAIT_IDLE;
         busy          <= 1'b0;
         bit_cnt       <= '0;
         bit_idx       <= '0;
         output_byte   <= '0;
         strobe_cnt    <= '0;
         framing_error <= 1'b0;
      end else begin
         state         <= next_state;
         busy          <= (next_state == START) || (next_state == DATA) || (next_state == STOP);
         bit_cnt       <= cnt_clr ? '0 : bit_cnt + CNT_W'(1);
         framing_error <= stop_err;
         if (idx_clr)
            bit_idx <= '0;
         else if (idx_inc)
            bit_idx <= bit_idx + 3'd1;
         if (load_byte)
            output_byte <= shreg;
         if (load_byte)
            strobe_cnt <= STB_LOAD;
         else if (strobe_cnt != '0)
            strobe_cnt <= strobe_cnt - STB_W'(1);
      end
   end

   // NOTE: the shift register is pure datapath; every bit is rewritten before it is
   // used, so it carries no reset.
   always_ff @(posedge clk) begin
      if (shift_en)
         shreg[bit_idx] <= rx_s;
   end

   assign accumulate = (strobe_cnt != '0);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at CLKS_PER_BIT=16, STROBE_CYCLES=4.
// A negedge monitor logs strobes, widths and error pulses; each test task checks the log.
module tb_uart_byte_receiver;

   localparam int CPB = 16;
   localparam int STB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] output_byte;
   logic       accumulate;
   logic       framing_error;
   logic       busy;

   int vectors    = 0;
   int miscompares = 0;

   uart_byte_receiver #(
      .CLKS_PER_BIT (CPB),
      .STROBE_CYCLES(STB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .output_byte  (output_byte),
      .accumulate   (accumulate),
      .framing_error(framing_error),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [7:0] byte_q[$];
   int         width_q[$];
   int         rise_q[$];
   int         fe_cnt    = 0;
   int         unstable  = 0;
   int         busy_seen = 0;
   logic       prev_acc  = 1'b0;
   logic [7:0] prev_byte = 8'h00;
   int         run       = 0;

   always @(negedge clk) begin
      if (framing_error === 1'b1) fe_cnt++;
      if (busy === 1'b1) busy_seen++;
      if (accumulate === 1'b1 && prev_acc !== 1'b1) begin
         byte_q.push_back(output_byte);
         rise_q.push_back(cyc);
         run = 1;
      end else if (accumulate === 1'b1) begin
         run++;
         if (output_byte !== prev_byte) unstable++;
      end else if (prev_acc === 1'b1) begin
         width_q.push_back(run);
      end
      prev_acc  = accumulate;
      prev_byte = output_byte;
   end

   function automatic logic [7:0] byte_at(input int i);
      if (i < byte_q.size()) return byte_q[i];
      return 8'hxx;
   endfunction

   function automatic int width_at(input int i);
      if (i < width_q.size()) return width_q[i];
      return -1;
   endfunction

   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
      drive(stop_bit, CPB);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (output_byte !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_output_byte got %h expected 00", output_byte);
      end
      vectors++;
      if (accumulate !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_accumulate got %b expected 0", accumulate);
      end
      vectors++;
      if (framing_error !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_framing_error got %b expected 0", framing_error);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy got %b expected 0", busy);
      end
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_byte();
      int nb, nf, start, lat;
      nb = byte_q.size();
      nf = fe_cnt;
      drive(1'b1, 20);
      start = cyc;
      send_byte(8'h41, 1'b1);
      drive(1'b1, 40);
      vectors++;
      if (byte_q.size() - nb !== 1) begin
         miscompares++;
         $display("FAIL single_count got %0d expected 1", byte_q.size() - nb);
      end
      vectors++;
      if (byte_at(nb) !== 8'h41) begin
         miscompares++;
         $display("FAIL single_byte got %h expected 41", byte_at(nb));
      end
      vectors++;
      if (width_at(nb) !== STB) begin
         miscompares++;
         $display("FAIL single_width got %0d expected %0d", width_at(nb), STB);
      end
      vectors++;
      if (fe_cnt !== nf) begin
         miscompares++;
         $display("FAIL single_no_error got %0d pulses expected 0", fe_cnt - nf);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_busy_after got %b expected 0", busy);
      end
      // Pin edge to strobe: 2 + 8 + 9*16 = 154, plus or minus one cycle.
      lat = (rise_q.size() > nb) ? rise_q[nb] - start : -1;
      vectors++;
      if (lat < 153 || lat > 155) begin
         miscompares++;
         $display("FAIL single_latency got %0d expected 153..155", lat);
      end
   endtask

   task automatic test_back_to_back();
      int nb, nu;
      logic [7:0] exp_b[3];
      exp_b[0] = 8'hBE;
      exp_b[1] = 8'hEF;
      exp_b[2] = 8'h0D;
      nb = byte_q.size();
      nu = unstable;
      for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1);
      drive(1'b1, 40);
      vectors++;
      if (byte_q.size() - nb !== 3) begin
         miscompares++;
         $display("FAIL b2b_count got %0d expected 3", byte_q.size() - nb);
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (byte_at(nb + i) !== exp_b[i]) begin
            miscompares++;
            $display("FAIL b2b_byte%0d got %h expected %h", i, byte_at(nb + i), exp_b[i]);
         end
         vectors++;
         if (width_at(nb + i) !== STB) begin
            miscompares++;
            $display("FAIL b2b_width%0d got %0d expected %0d", i, width_at(nb + i), STB);
         end
      end
      vectors++;
      if (unstable !== nu) begin
         miscompares++;
         $display("FAIL b2b_stable got %0d changes expected 0", unstable - nu);
      end
   endtask

   task automatic test_framing_error();
      int nb, nf;
      nb = byte_q.size();
      nf = fe_cnt;
      send_byte(8'h0D, 1'b0);
      drive(1'b1, 20);
      vectors++;
      if (fe_cnt - nf !== 1) begin
         miscompares++;
         $display("FAIL frame_err_pulses got %0d expected 1", fe_cnt - nf);
      end
      vectors++;
      if (byte_q.size() !== nb) begin
         miscompares++;
         $display("FAIL frame_err_strobe got %0d strobes expected 0", byte_q.size() - nb);
      end
      vectors++;
      if (output_byte !== 8'h0D) begin
         miscompares++;
         $display("FAIL frame_err_hold got %h expected 0d", output_byte);
      end
      send_byte(8'h55, 1'b1);
      drive(1'b1, 40);
      vectors++;
      if (byte_q.size() - nb !== 1 || byte_at(nb) !== 8'h55) begin
         miscompares++;
         $display("FAIL frame_recover got %h (count %0d) expected 55", byte_at(nb), byte_q.size() - nb);
      end
   endtask

   task automatic test_glitch();
      int nb, nf, nbusy;
      nb    = byte_q.size();
      nf    = fe_cnt;
      nbusy = busy_seen;
      drive(1'b0, 4);
      drive(1'b1, 40);
      vectors++;
      if (busy_seen <= nbusy) begin
         miscompares++;
         $display("FAIL glitch_busy_pulse got %0d busy cycles expected >0", busy_seen - nbusy);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_busy_after got %b expected 0", busy);
      end
      vectors++;
      if (byte_q.size() !== nb || fe_cnt !== nf) begin
         miscompares++;
         $display("FAIL glitch_quiet got %0d strobes %0d errors expected 0 0",
                  byte_q.size() - nb, fe_cnt - nf);
      end
   endtask

   task automatic test_reset_mid_frame();
      int nb, nf;
      drive(1'b1, 20);
      drive(1'b0, CPB);
      for (int i = 0; i < 3; i++) drive(1'b1, CPB);
      drive(1'b0, CPB / 2);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_busy_before got %b expected 1", busy);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if ({output_byte, accumulate, framing_error, busy} !== 11'b0) begin
         miscompares++;
         $display("FAIL midrst_outputs got byte=%h acc=%b fe=%b busy=%b expected all 0",
                  output_byte, accumulate, framing_error, busy);
      end
      rx = 1'b0;
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
      nb = byte_q.size();
      nf = fe_cnt;
      drive(1'b0, 60);
      vectors++;
      if (byte_q.size() !== nb || fe_cnt !== nf || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_low_hold got %0d strobes %0d errors busy=%b expected 0 0 0",
                  byte_q.size() - nb, fe_cnt - nf, busy);
      end
      drive(1'b1, 20);
      send_byte(8'hA5, 1'b1);
      drive(1'b1, 40);
      vectors++;
      if (byte_q.size() - nb !== 1 || byte_at(nb) !== 8'hA5) begin
         miscompares++;
         $display("FAIL midrst_recover got %h (count %0d) expected a5", byte_at(nb), byte_q.size() - nb);
      end
   endtask

   task automatic test_break();
      int nb, nf;
      nb = byte_q.size();
      nf = fe_cnt;
      drive(1'b0, 30 * CPB);
      vectors++;
      if (fe_cnt - nf !== 1) begin
         miscompares++;
         $display("FAIL break_pulses got %0d expected 1", fe_cnt - nf);
      end
      vectors++;
      if (byte_q.size() !== nb) begin
         miscompares++;
         $display("FAIL break_strobe got %0d strobes expected 0", byte_q.size() - nb);
      end
      drive(1'b1, 20);
      send_byte(8'h96, 1'b1);
      drive(1'b1, 40);
      vectors++;
      if (byte_q.size() - nb !== 1 || byte_at(nb) !== 8'h96) begin
         miscompares++;
         $display("FAIL break_recover got %h (count %0d) expected 96", byte_at(nb), byte_q.size() - nb);
      end
      vectors++;
      if (fe_cnt - nf !== 1) begin
         miscompares++;
         $display("FAIL break_total_pulses got %0d expected 1", fe_cnt - nf);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_framing_error();
      test_glitch();
      test_reset_mid_frame();
      test_break();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
